// File: rtl/a_to_five_pkg.sv
// Shared definitions for the a_to_five header-rewrite front end.
//
// Contents:
//   FRAME_W       - width of one parallel frame offered by a source
//   HDR_W         - width of the header nibble at the top of each frame
//   HDR_MATCH     - header value the datapath accepts
//   sched_state_t - scheduler FSM states (IDLE, SHIFT, GAP)
package a_to_five_pkg;

    localparam int          FRAME_W   = 12;
    localparam int          HDR_W     = 4;
    localparam logic [3:0]  HDR_MATCH = 4'hA;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

endpackage

// File: rtl/a_to_five_frame_sched_rr_arbiter.sv
// Purely combinational round-robin arbiter (module rr_arbiter).
//
// The search starts one position after last_grant and wraps modulo N_REQ,
// so the source granted most recently has the lowest priority next time.
//
// Ports:
//   req        in  [N_REQ-1:0]          request vector
//   last_grant in  [$clog2(N_REQ)-1:0]  index granted most recently
//   gnt        out [N_REQ-1:0]          one-hot grant (all zero if no request)
//   gnt_idx    out [$clog2(N_REQ)-1:0]  index of the granted source
//   any        out                      at least one request is pending
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     any
);

    localparam int IDX_W = $clog2(N_REQ);

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        // k = 1 first: the previous winner is visited last.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/a_to_five_frame_sched.sv
// Round-robin frame scheduler feeding the serial input of the a_to_five
// datapath. One of N_REQ parallel 12-bit sources is granted, its frame is
// shifted out MSB-first on ser_in/ser_valid, and at least 1+GAP_CYCLES idle
// cycles separate consecutive frames.
//
// Handshake: a source holds req_valid with its frame on req_frame; the frame
// is taken in the cycle where req_ready for that source is high. req_ready is
// combinational, only ever high in IDLE, one-hot, and low while rst is high.
//
// Optional feature (macro A_TO_FIVE_HDR_FILTER_EN): a winning frame whose
// header nibble is not HDR_MATCH is acknowledged but discarded, counted in
// the saturating drop_cnt output, and arbitration retries the next cycle.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   req_valid   [N_REQ]      per-source frame offered
//   req_frame   [N_REQ*12]   frame of source i at [i*12+11 : i*12]
//   req_ready   [N_REQ]      one-hot accept pulse
//   ser_in      serial bit to the datapath
//   ser_valid   serial bit qualifier
//   grant_id    owner of the current (last serialized) frame
//   busy        high while shifting or in the inter-frame gap
//   frame_done  pulse with the last bit of a frame
//   drop_cnt    [8] discarded-frame count (filter build only)
module a_to_five_frame_sched
    import a_to_five_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*FRAME_W-1:0] req_frame,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     ser_in,
    output logic                     ser_valid,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     frame_done
`ifdef A_TO_FIVE_HDR_FILTER_EN
    ,
    output logic [7:0]               drop_cnt
`endif
);

    localparam int IDX_W = $clog2(N_REQ);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_GAP   = GAP;

    logic [1:0]         state;
    logic [FRAME_W-1:0] shreg;
    logic [3:0]         bit_cnt;
    logic [15:0]        gap_cnt;
    logic [IDX_W-1:0]   last_grant;

    logic [N_REQ-1:0]   gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               any;
    logic [FRAME_W-1:0] win_frame;
    logic               keep;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    assign win_frame = req_frame[gnt_idx*FRAME_W +: FRAME_W];

`ifdef A_TO_FIVE_HDR_FILTER_EN
    assign keep = (win_frame[FRAME_W-1 -: HDR_W] == HDR_MATCH);
`else
    assign keep = 1'b1;
`endif

    assign req_ready  = (state == ST_IDLE && !rst) ? gnt : '0;

    // All serial-side outputs decode registered state only.
    assign ser_valid  = (state == ST_SHIFT);
    assign ser_in     = shreg[FRAME_W-1];
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_SHIFT) && (bit_cnt == 4'd11);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            last_grant <= IDX_W'(N_REQ - 1);
            grant_id   <= '0;
`ifdef A_TO_FIVE_HDR_FILTER_EN
            drop_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        // Discarded frames still move the pointer so a
                        // source with a bad header cannot starve others.
                        last_grant <= gnt_idx;
                        if (keep) begin
                            shreg    <= win_frame;
                            grant_id <= gnt_idx;
                            bit_cnt  <= '0;
                            state    <= ST_SHIFT;
                        end
`ifdef A_TO_FIVE_HDR_FILTER_EN
                        else if (drop_cnt != 8'hFF) begin
                            drop_cnt <= drop_cnt + 8'd1;
                        end
`endif
                    end
                end
                ST_SHIFT: begin
                    shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd11) begin
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                        state   <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 16'(GAP_CYCLES - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a_to_five_frame_sched.sv
// Self-checking bench for a_to_five_frame_sched. Two instances share clock
// and reset: dut (GAP_CYCLES=0) for arbitration/serialization checks against
// a frame-level reference model, dut_g (GAP_CYCLES=3) for gap timing.
module tb_a_to_five_frame_sched;

    localparam int N  = 4;
    localparam int FW = 12;
    localparam int G0 = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    rv, rv_g;
    logic [N*FW-1:0] rf, rf_g;
    logic [N-1:0]    rr, rr_g;
    logic            si, sv, busy, fd;
    logic            si_g, sv_g, busy_g, fd_g;
    logic [1:0]      gid, gid_g;
`ifdef A_TO_FIVE_HDR_FILTER_EN
    logic [7:0]      dc, dc_g;
`endif

    a_to_five_frame_sched #(.N_REQ(N), .GAP_CYCLES(G0)) dut (
        .clk(clk), .rst(rst), .req_valid(rv), .req_frame(rf), .req_ready(rr),
        .ser_in(si), .ser_valid(sv), .grant_id(gid), .busy(busy), .frame_done(fd)
`ifdef A_TO_FIVE_HDR_FILTER_EN
        , .drop_cnt(dc)
`endif
    );

    a_to_five_frame_sched #(.N_REQ(N), .GAP_CYCLES(3)) dut_g (
        .clk(clk), .rst(rst), .req_valid(rv_g), .req_frame(rf_g), .req_ready(rr_g),
        .ser_in(si_g), .ser_valid(sv_g), .grant_id(gid_g), .busy(busy_g), .frame_done(fd_g)
`ifdef A_TO_FIVE_HDR_FILTER_EN
        , .drop_cnt(dc_g)
`endif
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model (frame level) ----------------
    // Each accepted frame becomes 12 queued {done,bit} entries; the next
    // accept is allowed once 13+GAP cycles have passed since the last one.
    logic [1:0] exp_q[$];
    int         cyc = 0;
    int         m_free, m_lg, m_gid, m_drop;
    logic [N-1:0] e_rr;
    logic       e_sv, e_si, e_fd, e_busy;
    int         e_gid, e_drop;

    task automatic model_reset();
        m_free = cyc;
        m_lg   = N - 1;
        m_gid  = 0;
        m_drop = 0;
        exp_q.delete();
    endtask

    task automatic model_cycle();
        logic [1:0]    b;
        logic [FW-1:0] frame;
        int            w;
        bit            found;
        e_gid  = m_gid;
        e_drop = m_drop;
        e_busy = (cyc < m_free);
        if (exp_q.size() > 0) begin
            b    = exp_q.pop_front();
            e_sv = 1'b1; e_si = b[0]; e_fd = b[1];
        end else begin
            e_sv = 1'b0; e_si = 1'b0; e_fd = 1'b0;
        end
        e_rr = '0;
        if (cyc >= m_free && rv != '0) begin
            found = 0; w = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && rv[(m_lg + k) % N]) begin
                    found = 1; w = (m_lg + k) % N;
                end
            end
            e_rr[w] = 1'b1;
            m_lg    = w;
            frame   = rf[w*FW +: FW];
`ifdef A_TO_FIVE_HDR_FILTER_EN
            if (frame[11:8] != 4'hA) begin
                if (m_drop < 255) m_drop++;
                m_free = cyc + 1;
            end else
`endif
            begin
                for (int i = FW - 1; i >= 0; i--) exp_q.push_back({(i == 0), frame[i]});
                m_free = cyc + 13 + G0;
                m_gid  = w;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        rv = '0; rv_g = '0; rf = '0; rf_g = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rv = '0; rv_g = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rv = 4'hF; rf = {4{12'hA55}};
        repeat (3) begin
            @(negedge clk);
            total++; if (rr !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", rr); end
            total++; if (sv !== 1'b0 || busy !== 1'b0 || fd !== 1'b0 || si !== 1'b0) begin
                bad++; $display("FAIL reset_outs got sv=%b busy=%b fd=%b si=%b exp=0", sv, busy, fd, si); end
            total++; if (gid !== 2'd0) begin bad++; $display("FAIL reset_gid got=%0d exp=0", gid); end
`ifdef A_TO_FIVE_HDR_FILTER_EN
            total++; if (dc !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", dc); end
`endif
        end
        rst = 1'b0; rv = '0;
        @(posedge clk);
    endtask

    task automatic test_single_frame();
        logic [FW-1:0] got;
        int nbits, acc_at, fd_at, n;
        bit drop_req;
        do_reset(); model_reset();
        rv = 4'b0001; rf = '0; rf[11:0] = 12'hA3C;
        got = '0; nbits = 0; acc_at = -1; fd_at = -1; drop_req = 0;
        for (n = 0; n < 20; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
                if (drop_req) rv = '0;
            end
            @(negedge clk);
            model_cycle();
            total++; if (rr !== e_rr) begin bad++; $display("FAIL single_ready n=%0d got=%b exp=%b", n, rr, e_rr); end
            total++; if (sv !== e_sv) begin bad++; $display("FAIL single_sv n=%0d got=%b exp=%b", n, sv, e_sv); end
            total++; if (busy !== e_busy) begin bad++; $display("FAIL single_busy n=%0d got=%b exp=%b", n, busy, e_busy); end
            if (rr[0] === 1'b1 && acc_at < 0) begin acc_at = n; drop_req = 1; end
            if (sv === 1'b1) begin got = {got[10:0], si}; nbits++; end
            if (fd === 1'b1) fd_at = n;
        end
        total++; if (got !== 12'hA3C || nbits != 12) begin bad++; $display("FAIL single_bits got=%h/%0d exp=a3c/12", got, nbits); end
        total++; if (fd_at != acc_at + 12) begin bad++; $display("FAIL single_done got=%0d exp=%0d", fd_at, acc_at + 12); end
        total++; if (gid !== 2'd0) begin bad++; $display("FAIL single_gid got=%0d exp=0", gid); end
    endtask

    task automatic test_round_robin();
        int prev_id, prev_at, nacc;
        do_reset(); model_reset();
        rv = 4'hF;
        prev_id = -1; prev_at = -1; nacc = 0;
        for (int n = 0; n < 13 * 9; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            for (int i = 0; i < N; i++) rf[i*FW +: FW] = {4'hA, 8'($urandom)};
            @(negedge clk);
            model_cycle();
            total++; if (rr !== e_rr) begin bad++; $display("FAIL rr_ready n=%0d got=%b exp=%b", n, rr, e_rr); end
            total++; if (sv !== e_sv || fd !== e_fd) begin bad++; $display("FAIL rr_sv_fd n=%0d got=%b%b exp=%b%b", n, sv, fd, e_sv, e_fd); end
            if (e_sv) begin total++; if (si !== e_si) begin bad++; $display("FAIL rr_bit n=%0d got=%b exp=%b", n, si, e_si); end end
            total++; if (gid !== 2'(e_gid)) begin bad++; $display("FAIL rr_gid n=%0d got=%0d exp=%0d", n, gid, e_gid); end
            total++; if ($countones(rr) > 1) begin bad++; $display("FAIL rr_onehot n=%0d got=%b exp=<=1 bit", n, rr); end
            if (rr != '0) begin
                for (int i = 0; i < N; i++) if (rr[i]) begin
                    if (prev_id >= 0) begin
                        total++; if (i != (prev_id + 1) % N) begin bad++; $display("FAIL rr_order got=%0d exp=%0d", i, (prev_id + 1) % N); end
                        total++; if (n - prev_at != 13) begin bad++; $display("FAIL rr_spacing got=%0d exp=13", n - prev_at); end
                    end else begin
                        total++; if (i != 0) begin bad++; $display("FAIL rr_first got=%0d exp=0", i); end
                    end
                    prev_id = i; prev_at = n; nacc++;
                end
            end
        end
        total++; if (nacc != 9) begin bad++; $display("FAIL rr_count got=%0d exp=9", nacc); end
        rv = '0;
    endtask

    task automatic test_random();
        do_reset(); model_reset();
        for (int n = 0; n < 600; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            if ($urandom_range(0, 3) == 0) rv = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 2) == 0)
                    rf[i*FW +: FW] = {($urandom_range(0, 1) == 1) ? 4'hA : 4'($urandom), 8'($urandom)};
            @(negedge clk);
            model_cycle();
            total++; if (rr !== e_rr) begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, rr, e_rr); end
            total++; if (sv !== e_sv || fd !== e_fd) begin bad++; $display("FAIL rnd_sv_fd n=%0d got=%b%b exp=%b%b", n, sv, fd, e_sv, e_fd); end
            if (e_sv) begin total++; if (si !== e_si) begin bad++; $display("FAIL rnd_bit n=%0d got=%b exp=%b", n, si, e_si); end end
            total++; if (busy !== e_busy) begin bad++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, busy, e_busy); end
            total++; if (gid !== 2'(e_gid)) begin bad++; $display("FAIL rnd_gid n=%0d got=%0d exp=%0d", n, gid, e_gid); end
`ifdef A_TO_FIVE_HDR_FILTER_EN
            total++; if (dc !== 8'(e_drop)) begin bad++; $display("FAIL rnd_drop n=%0d got=%0d exp=%0d", n, dc, e_drop); end
`endif
        end
        rv = '0;
    endtask

    task automatic test_gap();
        int n, hi, lo, blo;
        do_reset();
        rv_g = 4'hF;
        for (int i = 0; i < N; i++) rf_g[i*FW +: FW] = {4'hA, 8'hC3};
        @(negedge clk);
        n = 0;
        while (sv_g !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        total++; if (n >= 50) begin bad++; $display("FAIL gap_start got=timeout exp=ser_valid"); end
        repeat (3) begin
            hi = 0;
            while (sv_g === 1'b1 && hi < 30) begin hi++; @(negedge clk); end
            total++; if (hi != 12) begin bad++; $display("FAIL gap_high got=%0d exp=12", hi); end
            lo = 0; blo = 0;
            while (sv_g !== 1'b1 && lo < 30) begin
                lo++;
                if (busy_g === 1'b1) blo++;
                @(negedge clk);
            end
            total++; if (lo != 4) begin bad++; $display("FAIL gap_low got=%0d exp=4", lo); end
            total++; if (blo != 3) begin bad++; $display("FAIL gap_busy got=%0d exp=3", blo); end
        end
        rv_g = '0;
    endtask

    task automatic test_reset_mid_frame();
        int n, bits;
        do_reset();
        rv = 4'b0100; rf = '0; rf[2*FW +: FW] = 12'hA55; rf[0 +: FW] = 12'hAF0;
        @(negedge clk);
        n = 0;
        while (rr[2] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        total++; if (n >= 20) begin bad++; $display("FAIL midrst_grant got=timeout exp=src2"); end
        bits = 0; n = 0;
        while (bits < 6 && n < 20) begin
            @(negedge clk); n++;
            if (sv === 1'b1) bits++;
        end
        // Reset sampled at the edge ending the 6th bit.
        rst = 1'b1;
        #1;
        total++; if (rr !== 4'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0000", rr); end
        @(posedge clk); #1;
        total++; if (sv !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_abort got sv=%b busy=%b exp=0", sv, busy); end
        rst = 1'b0; rv = 4'b0101;
        @(negedge clk);
        total++; if (rr !== 4'b0001) begin bad++; $display("FAIL midrst_prio got=%b exp=0001", rr); end
        @(posedge clk); #1; rv = 4'b0100;
        @(negedge clk);
        total++; if (sv !== 1'b1 || si !== 1'b1 || gid !== 2'd0) begin
            bad++; $display("FAIL midrst_resume got sv=%b si=%b gid=%0d exp 1 1 0", sv, si, gid); end
        rv = '0;
        repeat (14) @(posedge clk);
    endtask

`ifdef A_TO_FIVE_HDR_FILTER_EN
    task automatic test_filter();
        logic [FW-1:0] got;
        int nbits;
        do_reset();
        rv = 4'b0110; rf = '0; rf[1*FW +: FW] = 12'h5FF; rf[2*FW +: FW] = 12'hA01;
        @(negedge clk);
        total++; if (rr !== 4'b0010) begin bad++; $display("FAIL filt_first got=%b exp=0010", rr); end
        @(posedge clk); #1; rv = 4'b0100;
        @(negedge clk);
        total++; if (dc !== 8'd1) begin bad++; $display("FAIL filt_drop got=%0d exp=1", dc); end
        total++; if (sv !== 1'b0) begin bad++; $display("FAIL filt_noser got=%b exp=0", sv); end
        total++; if (rr !== 4'b0100) begin bad++; $display("FAIL filt_second got=%b exp=0100", rr); end
        @(posedge clk); #1; rv = '0;
        got = '0; nbits = 0;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (sv === 1'b1) begin got = {got[10:0], si}; nbits++; end
        end
        total++; if (got !== 12'hA01 || nbits != 12) begin bad++; $display("FAIL filt_bits got=%h/%0d exp=a01/12", got, nbits); end
        total++; if (gid !== 2'd2) begin bad++; $display("FAIL filt_gid got=%0d exp=2", gid); end
    endtask

    task automatic test_drop_sat();
        int sv_seen;
        do_reset();
        rv = 4'b0001; rf = '0; rf[0 +: FW] = 12'h5FF;
        sv_seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (sv === 1'b1) sv_seen++;
        end
        total++; if (dc !== 8'd255) begin bad++; $display("FAIL sat_drop got=%0d exp=255", dc); end
        total++; if (sv_seen != 0) begin bad++; $display("FAIL sat_noser got=%0d exp=0", sv_seen); end
        rv = '0;
    endtask
`endif

    initial begin
        rv = '0; rv_g = '0; rf = '0; rf_g = '0; rst = 1'b1;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_random();
        test_gap();
        test_reset_mid_frame();
`ifdef A_TO_FIVE_HDR_FILTER_EN
        test_filter();
        test_drop_sat();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/a_to_five_frame_sched.md
# a_to_five_frame_sched

Round-robin scheduler that shares the serial input of the `a_to_five` header-rewrite datapath between `N_REQ` frame sources. Each source offers a parallel 12-bit frame with a valid/ready handshake. The scheduler grants one source and serializes the frame MSB-first onto the `in`/`valid` pair of the datapath. It enforces an inter-frame gap between frames.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, range 2..8.
- `GAP_CYCLES`, default 0: extra idle cycles inserted after each frame, on top of the mandatory 1.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `req_valid`, input, `N_REQ`: per-source frame offered.
- `req_frame`, input, `N_REQ*12`: frame of source i at `[i*12+11 : i*12]`.
- `req_ready`, output, `N_REQ`: one-hot accept pulse (combinational, IDLE state only).
- `ser_in`, output, 1: serial bit to datapath `in`.
- `ser_valid`, output, 1: drives datapath `valid`.
- `grant_id`, output, `$clog2(N_REQ)`: index of the source owning the current frame.
- `busy`, output, 1: high in SHIFT and GAP.
- `frame_done`, output, 1: single-cycle pulse coincident with the last bit.
- `drop_cnt`, output, 8: present only with `A_TO_FIVE_HDR_FILTER_EN`.

## Operation
- FSM states are IDLE, SHIFT and GAP. Reset state is IDLE.
- IDLE:
  - If any `req_valid` is high, the round-robin winner g gets `req_ready[g]=1` that cycle.
  - Its frame loads into the 12-bit shift register and `grant_id<=g`.
  - Next state is SHIFT. If no request is pending, the FSM stays in IDLE.
- Round-robin:
  - Search starts at `last_grant+1` modulo `N_REQ`.
  - After reset, `last_grant = N_REQ-1`, so source 0 has top priority.
  - Only accepted frames update `last_grant`.
- SHIFT:
  - `ser_valid=1` and `ser_in=shreg[11]`; the register shifts left each cycle.
  - A 4-bit bit counter runs 0..11. At count 11, `frame_done=1`.
  - After count 11, the next state is GAP if `GAP_CYCLES>0`, else IDLE.
- GAP: `ser_valid=0`; a counter runs `GAP_CYCLES` cycles, then the next state is IDLE.
- Bit order: `frame[11]` is sent first, so `frame[11:8]` is the header seen first by the datapath.
- `req_ready` is never asserted outside IDLE. A source whose `req_valid` drops before grant is simply not served.
- Simultaneous requests: exactly one grant per IDLE cycle, never more than one `req_ready` bit.
- Registered outputs `ser_in`, `ser_valid`, `busy`, `frame_done`, `grant_id` and `drop_cnt` all reset to 0. `req_ready` is 0 while `rst` is high.
- Reset mid-frame: the frame is aborted, not retried; `ser_valid` is 0 from the cycle after the reset edge.

## Timing
- Accept cycle T: `req_ready[g]` high.
- `ser_valid` is high T+1..T+12 carrying bits 11..0. `frame_done` pulses at T+12.
- Earliest next accept is T+13+`GAP_CYCLES`, so there are at least 1+`GAP_CYCLES` idle cycles between frames.
- Sustained throughput: one frame per 13+`GAP_CYCLES` cycles.
- `busy` is high T+1 through the last GAP cycle.

## Configuration
- Macro: `A_TO_FIVE_HDR_FILTER_EN`.
- Defined:
  - In IDLE, a winning frame with `frame[11:8] != 4'hA` is still accepted (`req_ready` pulse, `last_grant` updated) but not serialized.
  - The FSM stays in IDLE and the next arbitration happens in the following cycle.
  - `drop_cnt` increments and saturates at 255.
- Undefined: every frame is serialized and the `drop_cnt` port and logic are absent.

## Structure
- Package `a_to_five_pkg` holds:
  - `FRAME_W=12`, `HDR_W=4` and `HDR_MATCH=4'hA`.
  - The `sched_state_t` enum {IDLE, SHIFT, GAP}.
- Sub-module `rr_arbiter`, parameterized on `N_REQ`, takes `req` and `last_grant`. It outputs one-hot `gnt`, `gnt_idx` and `any`. It is purely combinational.
- The pointer register lives in the scheduler.

## Test plan
- Single source 0 with frame 12'hA3C, accepted at T → `ser_in` T+1..T+12 = 1010_0011_1100, `frame_done` at T+12, `grant_id`=0.
- All 4 sources valid continuously, `GAP_CYCLES`=0 → grant order 0,1,2,3,0…; accepts exactly 13 cycles apart; never two `req_ready` bits high.
- `GAP_CYCLES`=3, back-to-back requests → `ser_valid` low for exactly 4 cycles between frames.
- `rst` asserted at the 6th bit → `ser_valid`=0 from the next cycle, FSM in IDLE; after release, source 0 wins over pending source 2.
- With `A_TO_FIVE_HDR_FILTER_EN`: source 1 offers 12'h5FF, source 2 offers 12'hA01 → source 1 gets a ready pulse with no serialization and `drop_cnt`=1; source 2 is accepted the next cycle and serialized.
- With `A_TO_FIVE_HDR_FILTER_EN`: 300 bad-header frames → `drop_cnt` holds at 255.
